// File: rtl/mult_nm_bit_if.sv
// ---------------------------------------------------------------------------
// mult_nm_bit_if
// Operand/result bundle for the mult_nm_bit unsigned array multiplier.
//
// Signals:
//   in_valid  : operands A/B valid this cycle          (master -> slave)
//   A         : N-bit unsigned multiplicand            (master -> slave)
//   B         : M-bit unsigned multiplier              (master -> slave)
//   Prod      : (N+M)-bit registered product A*B       (slave -> master)
//   out_valid : Prod holds a new result this cycle     (slave -> master)
//
// Modports:
//   master : operand source / result consumer
//   slave  : the multiplier
// ---------------------------------------------------------------------------
interface mult_nm_bit_if #(
    parameter int N = 4,
    parameter int M = 5
);
    logic             in_valid;
    logic [N-1:0]     A;
    logic [M-1:0]     B;
    logic [N+M-1:0]   Prod;
    logic             out_valid;

    modport master (
        output in_valid,
        output A,
        output B,
        input  Prod,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  A,
        input  B,
        output Prod,
        output out_valid
    );
endinterface

// File: rtl/mult_nm_bit.sv
// ---------------------------------------------------------------------------
// mult_nm_bit
// Unsigned N-bit x M-bit structural array multiplier with a registered
// full-precision (N+M)-bit product and a valid flag travelling with it.
// Partial products pp[j][i] = A[i] & B[j] are reduced row by row with
// ripple-carry adder chains; no '*' operator is used.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset (clears all registers)
//   bus  : mult_nm_bit_if.slave -- in_valid, A, B in; Prod, out_valid out
//
// Build option:
//   MULT_NM_PIPE_IN_EN : when defined, A/B/in_valid are registered before
//                        the array (latency 2). Otherwise latency is 1.
// ---------------------------------------------------------------------------
module mult_nm_bit #(
    parameter int N = 4,
    parameter int M = 5
) (
    input  logic            clk,
    input  logic            rst,
    mult_nm_bit_if.slave    bus
);

    localparam int P = N + M;

    logic [N-1:0] a_op;
    logic [M-1:0] b_op;
    logic         vld_op;

`ifdef MULT_NM_PIPE_IN_EN
    // ---- stage p0: input registers ----
    logic [N-1:0] a_p0_q, a_p0_d;
    logic [M-1:0] b_p0_q, b_p0_d;
    logic         vld_p0_q, vld_p0_d;

    // Operands only load on a valid beat so idle-cycle garbage never
    // reaches the array; the valid bit tracks in_valid every cycle.
    always_comb begin
        a_p0_d   = a_p0_q;
        b_p0_d   = b_p0_q;
        vld_p0_d = bus.in_valid;
        if (bus.in_valid) begin
            a_p0_d = bus.A;
            b_p0_d = bus.B;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_p0_q   <= '0;
            b_p0_q   <= '0;
            vld_p0_q <= 1'b0;
        end else begin
            a_p0_q   <= a_p0_d;
            b_p0_q   <= b_p0_d;
            vld_p0_q <= vld_p0_d;
        end
    end

    assign a_op   = a_p0_q;
    assign b_op   = b_p0_q;
    assign vld_op = vld_p0_q;
`else
    assign a_op   = bus.A;
    assign b_op   = bus.B;
    assign vld_op = bus.in_valid;
`endif

    // ---- array: combinational partial-product reduction ----
    // Row j holds an (N+1)-bit running sum. Its LSB is final product bit j;
    // the upper N bits are shifted down and added to the next partial
    // product row. The last row supplies the top N+1 product bits.
    logic [P-1:0] prod_w;

    for (genvar j = 0; j < M; j++) begin : g_row
        logic [N:0] acc;

        if (j == 0) begin : g_first
            assign acc = {1'b0, a_op & {N{b_op[0]}}};
        end else begin : g_add
            always_comb begin
                logic pp;
                logic x;
                logic c;
                // Bit 0 has no carry in, so the chain starts as a half adder.
                c   = 1'b0;
                acc = '0;
                for (int i = 0; i < N; i++) begin
                    pp     = a_op[i] & b_op[j];
                    x      = g_row[j-1].acc[i+1];
                    acc[i] = pp ^ x ^ c;
                    c      = (pp & x) | (c & (pp ^ x));
                end
                acc[N] = c;
            end
        end

        if (j < M - 1) begin : g_lsb
            assign prod_w[j] = acc[0];
        end
    end

    assign prod_w[P-1:M-1] = g_row[M-1].acc;

    // ---- stage p1: output register ----
    logic [P-1:0] prod_p1_q, prod_p1_d;
    logic         vld_p1_q, vld_p1_d;

    always_comb begin
        prod_p1_d = prod_p1_q;
        vld_p1_d  = vld_op;
        if (vld_op) begin
            prod_p1_d = prod_w;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_p1_q <= '0;
            vld_p1_q  <= 1'b0;
        end else begin
            prod_p1_q <= prod_p1_d;
            vld_p1_q  <= vld_p1_d;
        end
    end

    assign bus.Prod      = prod_p1_q;
    assign bus.out_valid = vld_p1_q;

endmodule

// File: tb/tb_mult_nm_bit.sv
// ---------------------------------------------------------------------------
// tb_mult_nm_bit
// Directed self-checking bench for mult_nm_bit (N=4, M=5).
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mult_nm_bit;

    localparam int N = 4;
    localparam int M = 5;
`ifdef MULT_NM_PIPE_IN_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    mult_nm_bit_if #(.N(N), .M(M)) bus ();

    mult_nm_bit #(.N(N), .M(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [N-1:0] a, input logic [M-1:0] b, input logic v);
        bus.A        = a;
        bus.B        = b;
        bus.in_valid = v;
    endtask

    task automatic test_reset();
        drive(4'd0, 5'd0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if (bus.Prod !== 9'd0) $display("FAIL reset_prod: got %0d want 0", bus.Prod);
        else pass_cnt++;
        chk_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_vld: got %b want 0", bus.out_valid);
        else pass_cnt++;
        rst = 1'b0;

        // Load a non-zero product, then hit reset between clock edges.
        @(negedge clk);
        drive(4'd3, 5'd2, 1'b1);
        repeat (LAT) @(negedge clk);
        chk_cnt++;
        if (bus.Prod !== 9'd6) $display("FAIL pre_async_prod: got %0d want 6", bus.Prod);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        chk_cnt++;
        if (bus.Prod !== 9'd0) $display("FAIL async_rst_prod: got %0d want 0", bus.Prod);
        else pass_cnt++;
        chk_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL async_rst_vld: got %b want 0", bus.out_valid);
        else pass_cnt++;
        drive(4'd0, 5'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        drive(4'd3, 5'd2, 1'b1);
        repeat (LAT) @(negedge clk);
        chk_cnt++;
        if (bus.Prod !== 9'd6) $display("FAIL basic_3x2: got %0d want 6", bus.Prod);
        else pass_cnt++;
        chk_cnt++;
        if (bus.out_valid !== 1'b1) $display("FAIL basic_3x2_vld: got %b want 1", bus.out_valid);
        else pass_cnt++;
        drive(4'd5, 5'd5, 1'b1);
        repeat (LAT) @(negedge clk);
        chk_cnt++;
        if (bus.Prod !== 9'd25) $display("FAIL basic_5x5: got %0d want 25", bus.Prod);
        else pass_cnt++;
        drive(4'd9, 5'd17, 1'b0);
        repeat (LAT) @(negedge clk);
        chk_cnt++;
        if (bus.Prod !== 9'd25) $display("FAIL basic_idle_prod: got %0d want 25", bus.Prod);
        else pass_cnt++;
        chk_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL basic_idle_vld: got %b want 0", bus.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] av  [4] = '{4'd15, 4'd10, 4'd0,  4'd9};
        logic [M-1:0] bv  [4] = '{5'd3,  5'd1,  5'd31, 5'd0};
        logic [8:0]   exp [4] = '{9'd45, 9'd10, 9'd0,  9'd0};
        drive(av[0], bv[0], 1'b1);
        for (int t = 1; t < 4 + LAT; t++) begin
            int k;
            @(negedge clk);
            k = t - LAT;
            if (k >= 0) begin
                chk_cnt++;
                if (bus.Prod !== exp[k]) $display("FAIL b2b_prod[%0d]: got %0d want %0d", k, bus.Prod, exp[k]);
                else pass_cnt++;
                chk_cnt++;
                if (bus.out_valid !== 1'b1) $display("FAIL b2b_vld[%0d]: got %b want 1", k, bus.out_valid);
                else pass_cnt++;
            end
            if (t < 4) drive(av[t], bv[t], 1'b1);
            else       drive(4'd0, 5'd0, 1'b0);
        end
        repeat (LAT) @(negedge clk);
    endtask

    task automatic test_max();
        drive(4'd15, 5'd31, 1'b1);
        repeat (LAT) @(negedge clk);
        chk_cnt++;
        if (bus.Prod !== 9'b111010001) $display("FAIL max_15x31: got %0d want 465", bus.Prod);
        else pass_cnt++;
        chk_cnt++;
        if (bus.out_valid !== 1'b1) $display("FAIL max_vld: got %b want 1", bus.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_hold();
        drive(4'($urandom_range(15)), 5'($urandom_range(31)), 1'b0);
        for (int i = 0; i < 5 + LAT - 1; i++) begin
            @(negedge clk);
            if (i >= LAT - 1) begin
                chk_cnt++;
                if (bus.Prod !== 9'd465) $display("FAIL hold_prod[%0d]: got %0d want 465", i, bus.Prod);
                else pass_cnt++;
                chk_cnt++;
                if (bus.out_valid !== 1'b0) $display("FAIL hold_vld[%0d]: got %b want 0", i, bus.out_valid);
                else pass_cnt++;
            end
            drive(4'($urandom_range(15)), 5'($urandom_range(31)), 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        drive(4'd7, 5'd9, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk_cnt++;
        if (bus.Prod !== 9'd0) $display("FAIL midrst_prod: got %0d want 0", bus.Prod);
        else pass_cnt++;
        chk_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL midrst_vld: got %b want 0", bus.out_valid);
        else pass_cnt++;
        drive(4'd7, 5'd9, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_cnt++;
            if (bus.out_valid !== 1'b0) $display("FAIL postrst_vld[%0d]: got %b want 0", i, bus.out_valid);
            else pass_cnt++;
            chk_cnt++;
            if (bus.Prod !== 9'd0) $display("FAIL postrst_prod[%0d]: got %0d want 0", i, bus.Prod);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_max();
        test_hold();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", pass_cnt, chk_cnt);
        $fatal(1);
    end

endmodule
